// File: rtl/lsu_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_if
//  Description : Load/store unit between the MEM-stage pipeline register and
//                a word-wide data memory. One request at a time over a
//                valid/ready handshake; byte/half/word loads with sign or
//                zero extension; sub-word stores as read-modify-write.
//                Optional feature macro: LSU_MISALIGN_TRAP_EN
//                  defined   : misaligned half/word requests return an
//                              exception response with no memory access.
//                  undefined : offending low address bits are cleared and
//                              the access proceeds normally.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_if #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_exc,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_RDW  = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;

    state_t             r_state;
    state_t             w_state_nxt;

    // Latched request fields, held for the whole operation
    logic               r_we;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic [MEM_AW-1:0]  r_word_addr;
    logic [1:0]         r_lane;
    logic [15:0]        r_wdata_lo;
    logic [31:0]        r_wbuf;

    logic               r_resp_valid;
    logic               r_resp_exc;
    logic [31:0]        r_resp_rdata;

    logic               w_accept;
    logic               w_size_word;
    logic               w_size_half;
    logic               w_misalign;
    logic [1:0]         w_lane_in;
    logic [7:0]         w_lane_byte;
    logic [15:0]        w_lane_half;
    logic [31:0]        w_load_data;
    logic [31:0]        w_merge;

    // Address bits above the memory window only wrap; they carry no meaning
    logic               w_unused_addr_hi;
    assign w_unused_addr_hi = ^req_addr[31:MEM_AW+2];

    assign w_accept    = req_valid && (r_state == ST_IDLE);
    assign w_size_word = req_size[1];
    assign w_size_half = (req_size == c_SIZE_HALF);

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned half/word requests are reported, never executed
    assign w_misalign = w_accept &&
                        ((w_size_half && req_addr[0]) ||
                         (w_size_word && (req_addr[1:0] != 2'b00)));
    assign w_lane_in  = req_addr[1:0];
`else
    // Misalignment is silently repaired by clearing the offending lane bits
    assign w_misalign   = 1'b0;
    assign w_lane_in[1] = req_addr[1] & ~w_size_word;
    assign w_lane_in[0] = req_addr[0] & ~(w_size_word | w_size_half);
`endif

    // State register; asynchronous reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_misalign) begin
                    if (req_we && w_size_word) begin
                        w_state_nxt = ST_WR;
                    end else begin
                        w_state_nxt = ST_RD;
                    end
                end
            end
            ST_RD:   w_state_nxt = ST_RDW;
            ST_RDW:  w_state_nxt = r_we ? ST_WR : ST_IDLE;
            ST_WR:   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Lane extraction and extension of the returned memory word
    always_comb begin
        w_lane_byte = mem_rdata[7:0];
        case (r_lane)
            2'd0:    w_lane_byte = mem_rdata[7:0];
            2'd1:    w_lane_byte = mem_rdata[15:8];
            2'd2:    w_lane_byte = mem_rdata[23:16];
            default: w_lane_byte = mem_rdata[31:24];
        endcase
        w_lane_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        if (r_size[1]) begin
            w_load_data = mem_rdata;
        end else if (r_size == c_SIZE_HALF) begin
            w_load_data = {{16{w_lane_half[15] & ~r_unsigned}}, w_lane_half};
        end else begin
            w_load_data = {{24{w_lane_byte[7] & ~r_unsigned}}, w_lane_byte};
        end
    end

    // Read-modify-write merge of store data into the target lane(s)
    always_comb begin
        w_merge = mem_rdata;
        if (r_size == c_SIZE_BYTE) begin
            case (r_lane)
                2'd0:    w_merge[7:0]   = r_wdata_lo[7:0];
                2'd1:    w_merge[15:8]  = r_wdata_lo[7:0];
                2'd2:    w_merge[23:16] = r_wdata_lo[7:0];
                default: w_merge[31:24] = r_wdata_lo[7:0];
            endcase
        end else if (r_size == c_SIZE_HALF) begin
            if (r_lane[1]) begin
                w_merge[31:16] = r_wdata_lo;
            end else begin
                w_merge[15:0]  = r_wdata_lo;
            end
        end
    end

    // Request latching, write buffer and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_word_addr  <= '0;
            r_lane       <= 2'b00;
            r_wdata_lo   <= 16'h0000;
            r_wbuf       <= 32'h0000_0000;
            r_resp_valid <= 1'b0;
            r_resp_exc   <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_exc   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we        <= req_we;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_word_addr <= req_addr[MEM_AW+1:2];
                        r_lane      <= w_lane_in;
                        r_wdata_lo  <= req_wdata[15:0];
                        if (w_misalign) begin
                            r_resp_valid <= 1'b1;
                            r_resp_exc   <= 1'b1;
                        end else if (req_we && w_size_word) begin
                            r_wbuf <= req_wdata;
                        end
                    end
                end
                ST_RDW: begin
                    if (r_we) begin
                        r_wbuf <= w_merge;
                    end else begin
                        r_resp_rdata <= w_load_data;
                        r_resp_valid <= 1'b1;
                    end
                end
                ST_WR: begin
                    r_resp_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Strobes depend on state alone so reset removes them immediately
    assign req_ready  = (r_state == ST_IDLE);
    assign mem_re     = (r_state == ST_RD);
    assign mem_we     = (r_state == ST_WR);
    assign mem_addr   = r_word_addr;
    assign mem_wdata  = r_wbuf;
    assign resp_valid = r_resp_valid;
    assign resp_exc   = r_resp_exc;
    assign resp_rdata = r_resp_rdata;

endmodule
`default_nettype wire
